// File: rtl/apb_master_gen_if.sv
// APB4 requester-to-completer bus bundle.
// The master modport is the requester view; the slave modport is the completer view.
interface apb_master_gen_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
) ();
    localparam int unsigned STRB_W = DATA_W / 8;

    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [STRB_W-1:0] PSTRB;
    logic [2:0]        PPROT;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_master_gen.sv
// APB4 requester: turns valid/ready commands into SETUP/ACCESS transfers.
// It returns a one-cycle response pulse and aborts a stalled transfer after TIMEOUT wait cycles.
module apb_master_gen #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                PCLK,
    input  logic                PRESET,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_strb,
    input  logic [2:0]          req_prot,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                rsp_timeout,
    apb_master_gen_if.master    apb
);
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned CNT_W  = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT - 1);

    logic [1:0]        state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic              accept;
    logic              timeout_hit;

    logic              psel_d, penable_d, pwrite_d;
    logic [ADDR_W-1:0] paddr_d;
    logic [DATA_W-1:0] pwdata_d;
    logic [STRB_W-1:0] pstrb_d;
    logic [2:0]        pprot_d;
    logic              rsp_valid_d, rsp_err_d, rsp_timeout_d;
    logic [DATA_W-1:0] rsp_rdata_d;

    // Ready is held low while reset is asserted so that every output reads 0.
    assign req_ready   = PRESET && ((state == IDLE) || ((state == ACCESS) && apb.PREADY));
    assign accept      = req_valid && req_ready;
    assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LIMIT);

    // Next state plus next value of every registered output
    always_comb begin
        state_d       = state;
        cnt_d         = cnt;
        pwrite_d      = apb.PWRITE;
        paddr_d       = apb.PADDR;
        pwdata_d      = apb.PWDATA;
        pstrb_d       = apb.PSTRB;
        pprot_d       = apb.PPROT;
        rsp_valid_d   = 1'b0;
        rsp_err_d     = 1'b0;
        rsp_timeout_d = 1'b0;
        rsp_rdata_d   = '0;

        case (state)
            IDLE: begin
                if (accept) state_d = SETUP;
            end
            SETUP: begin
                state_d = ACCESS;
                cnt_d   = '0;
            end
            ACCESS: begin
                if (apb.PREADY) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = apb.PSLVERR;
                    rsp_rdata_d = apb.PWRITE ? '0 : apb.PRDATA;
                    state_d     = accept ? SETUP : IDLE;
                end else if (timeout_hit) begin
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    state_d       = IDLE;
                end else if (cnt != CNT_MAX) begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Read transfers drive zero write data and strobes
        if (accept) begin
            pwrite_d = req_write;
            paddr_d  = req_addr;
            pprot_d  = req_prot;
            pwdata_d = req_write ? req_wdata : '0;
            pstrb_d  = req_write ? req_strb : '0;
        end

        psel_d    = (state_d != IDLE);
        penable_d = (state_d == ACCESS);
    end

    // State, counter and output registers
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            state       <= IDLE;
            cnt         <= '0;
            apb.PSEL    <= 1'b0;
            apb.PENABLE <= 1'b0;
            apb.PWRITE  <= 1'b0;
            apb.PADDR   <= '0;
            apb.PWDATA  <= '0;
            apb.PSTRB   <= '0;
            apb.PPROT   <= '0;
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= '0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            apb.PSEL    <= psel_d;
            apb.PENABLE <= penable_d;
            apb.PWRITE  <= pwrite_d;
            apb.PADDR   <= paddr_d;
            apb.PWDATA  <= pwdata_d;
            apb.PSTRB   <= pstrb_d;
            apb.PPROT   <= pprot_d;
            rsp_valid   <= rsp_valid_d;
            rsp_err     <= rsp_err_d;
            rsp_timeout <= rsp_timeout_d;
            rsp_rdata   <= rsp_rdata_d;
        end
    end
endmodule

// File: tb/tb_apb_master_gen.sv
// Bench for apb_master_gen: directed and random transfers checked against a transaction-level model.
// A second instance with TIMEOUT=0 checks that a long stall never aborts.
module tb_apb_master_gen;
    localparam int unsigned AW = 8;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;
    localparam int unsigned TO = 4;

    logic PCLK = 1'b0;
    logic PRESET;
    always #5 PCLK = ~PCLK;

    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [SW-1:0] req_strb;
    logic [2:0]    req_prot;
    logic          rsp_valid, rsp_err, rsp_timeout;
    logic [DW-1:0] rsp_rdata;

    logic          z_valid, z_ready, z_write;
    logic [AW-1:0] z_addr;
    logic [DW-1:0] z_wdata;
    logic [SW-1:0] z_strb;
    logic [2:0]    z_prot;
    logic          z_rsp_valid, z_rsp_err, z_rsp_timeout;
    logic [DW-1:0] z_rsp_rdata;

    apb_master_gen_if #(.ADDR_W(AW), .DATA_W(DW)) bus  ();
    apb_master_gen_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();

    apb_master_gen #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .apb(bus.master)
    );

    apb_master_gen #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(0)) dut0 (
        .PCLK(PCLK), .PRESET(PRESET),
        .req_valid(z_valid), .req_ready(z_ready), .req_write(z_write),
        .req_addr(z_addr), .req_wdata(z_wdata), .req_strb(z_strb), .req_prot(z_prot),
        .rsp_valid(z_rsp_valid), .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err), .rsp_timeout(z_rsp_timeout),
        .apb(bus0.master)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One complete transfer; expected results come from the transfer-level rules
    task automatic txn(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input logic [SW-1:0] st, input logic [2:0] pr, input int waits,
                       input logic err, input logic [DW-1:0] rd);
        bit            exp_to    = (TO > 0) && (waits >= int'(TO));
        int            nacc      = exp_to ? int'(TO) : waits + 1;
        logic [DW-1:0] exp_wd    = w ? wd : '0;
        logic [SW-1:0] exp_st    = w ? st : '0;
        logic          exp_err   = exp_to ? 1'b1 : err;
        logic [DW-1:0] exp_rdata = (exp_to || w) ? '0 : rd;

        @(negedge PCLK);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = wd; req_strb = st; req_prot = pr;
        #1;
        chk("idle_ready", 64'(req_ready), 64'(1));
        chk("idle_psel", 64'(bus.PSEL), 64'(0));

        @(negedge PCLK);
        req_valid = 1'b0;
        req_addr  = AW'($urandom); req_wdata = $urandom; req_strb = SW'($urandom);
        req_write = 1'($urandom);  req_prot  = 3'($urandom);
        #1;
        chk("setup_psel",    64'(bus.PSEL),    64'(1));
        chk("setup_penable", 64'(bus.PENABLE), 64'(0));
        chk("setup_ready",   64'(req_ready),   64'(0));
        chk("setup_paddr",   64'(bus.PADDR),   64'(a));
        chk("setup_pwrite",  64'(bus.PWRITE),  64'(w));
        chk("setup_pwdata",  64'(bus.PWDATA),  64'(exp_wd));
        chk("setup_pstrb",   64'(bus.PSTRB),   64'(exp_st));
        chk("setup_pprot",   64'(bus.PPROT),   64'(pr));

        for (int i = 0; i < nacc; i++) begin
            @(negedge PCLK);
            bus.PREADY  = (i == waits);
            bus.PSLVERR = (i == waits) ? err : 1'($urandom);
            bus.PRDATA  = (i == waits) ? rd : $urandom;
            #1;
            chk("access_penable", 64'(bus.PENABLE), 64'(1));
            chk("access_psel",    64'(bus.PSEL),    64'(1));
            chk("access_paddr",   64'(bus.PADDR),   64'(a));
            chk("access_pwdata",  64'(bus.PWDATA),  64'(exp_wd));
            chk("access_pstrb",   64'(bus.PSTRB),   64'(exp_st));
            chk("access_ready",   64'(req_ready),   64'(i == waits));
            chk("access_rsp",     64'(rsp_valid),   64'(0));
        end

        @(negedge PCLK);
        bus.PREADY = 1'b0; bus.PSLVERR = 1'b0; bus.PRDATA = $urandom;
        #1;
        chk("rsp_valid",   64'(rsp_valid),   64'(1));
        chk("rsp_err",     64'(rsp_err),     64'(exp_err));
        chk("rsp_timeout", 64'(rsp_timeout), 64'(exp_to));
        chk("rsp_rdata",   64'(rsp_rdata),   64'(exp_rdata));
        chk("end_psel",    64'(bus.PSEL),    64'(0));
        chk("end_penable", 64'(bus.PENABLE), 64'(0));
        chk("end_paddr",   64'(bus.PADDR),   64'(a));

        @(negedge PCLK);
        #1;
        chk("rsp_pulse", 64'(rsp_valid), 64'(0));
    endtask

    initial begin
        req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_strb = 0; req_prot = 0;
        z_valid = 0; z_write = 0; z_addr = 0; z_wdata = 0; z_strb = 0; z_prot = 0;
        bus.PREADY = 0; bus.PSLVERR = 0; bus.PRDATA = 0;
        bus0.PREADY = 0; bus0.PSLVERR = 0; bus0.PRDATA = 0;
        PRESET = 1'b0;
        #12;
        chk("rst_ready",  64'(req_ready),  64'(0));
        chk("rst_psel",   64'(bus.PSEL),   64'(0));
        chk("rst_paddr",  64'(bus.PADDR),  64'(0));
        chk("rst_rsp",    64'(rsp_valid),  64'(0));
        @(negedge PCLK);
        PRESET = 1'b1;

        // Test-plan directed transfers
        txn(1'b1, 8'h3C, 32'hDEADBEEF, 4'hF, 3'h0, 0, 1'b0, 32'h0);
        txn(1'b0, 8'h10, 32'hAAAA5555, 4'hF, 3'h2, 3, 1'b0, 32'h12345678);
        txn(1'b0, 8'h20, 32'h0,        4'h0, 3'h1, 2, 1'b1, 32'h0BAD0BAD);
        txn(1'b1, 8'h44, 32'h01020304, 4'h3, 3'h7, 9, 1'b0, 32'h0);

        // Back-to-back write 0x04 then read 0x08 with one wait state
        @(negedge PCLK);
        req_valid = 1; req_write = 1; req_addr = 8'h04; req_wdata = 32'hCAFE0004; req_strb = 4'hF; req_prot = 0;
        #1; chk("b2b_ready0", 64'(req_ready), 64'(1));
        @(negedge PCLK);
        req_write = 0; req_addr = 8'h08; req_wdata = 32'hFFFFFFFF; req_strb = 4'hF; req_prot = 3'h5;
        #1; chk("b2b_setup1_paddr", 64'(bus.PADDR), 64'(8'h04));
        chk("b2b_setup1_ready", 64'(req_ready), 64'(0));
        @(negedge PCLK);
        bus.PREADY = 1;
        #1; chk("b2b_access1_ready", 64'(req_ready), 64'(1));
        @(negedge PCLK);
        req_valid = 0; bus.PREADY = 0;
        #1; chk("b2b_setup2_psel", 64'(bus.PSEL), 64'(1));
        chk("b2b_setup2_penable", 64'(bus.PENABLE), 64'(0));
        chk("b2b_setup2_paddr",   64'(bus.PADDR),   64'(8'h08));
        chk("b2b_setup2_pwdata",  64'(bus.PWDATA),  64'(0));
        chk("b2b_setup2_pprot",   64'(bus.PPROT),   64'(3'h5));
        chk("b2b_rsp1_valid",     64'(rsp_valid),   64'(1));
        chk("b2b_rsp1_rdata",     64'(rsp_rdata),   64'(0));
        @(negedge PCLK);
        #1; chk("b2b_wait_rsp", 64'(rsp_valid), 64'(0));
        @(negedge PCLK);
        bus.PREADY = 1; bus.PRDATA = 32'h87654321;
        #1; chk("b2b_access2_penable", 64'(bus.PENABLE), 64'(1));
        @(negedge PCLK);
        bus.PREADY = 0;
        #1; chk("b2b_rsp2_valid", 64'(rsp_valid), 64'(1));
        chk("b2b_rsp2_rdata", 64'(rsp_rdata), 64'(32'h87654321));
        chk("b2b_end_psel",   64'(bus.PSEL),  64'(0));

        // Random transfers, waits spanning both sides of the timeout
        for (int k = 0; k < 24; k++) begin
            txn(1'($urandom), AW'($urandom), $urandom, SW'($urandom), 3'($urandom),
                int'($urandom_range(0, 6)), 1'($urandom), $urandom);
        end

        // Asynchronous reset during a wait state
        @(negedge PCLK);
        req_valid = 1; req_write = 1; req_addr = 8'h55; req_wdata = 32'h11223344; req_strb = 4'h6; req_prot = 3'h3;
        @(negedge PCLK);
        req_valid = 0;
        @(negedge PCLK);
        @(negedge PCLK);
        #2 PRESET = 1'b0;
        #1;
        chk("arst_psel",    64'(bus.PSEL),    64'(0));
        chk("arst_penable", 64'(bus.PENABLE), 64'(0));
        chk("arst_pwrite",  64'(bus.PWRITE),  64'(0));
        chk("arst_paddr",   64'(bus.PADDR),   64'(0));
        chk("arst_pwdata",  64'(bus.PWDATA),  64'(0));
        chk("arst_pstrb",   64'(bus.PSTRB),   64'(0));
        chk("arst_pprot",   64'(bus.PPROT),   64'(0));
        chk("arst_ready",   64'(req_ready),   64'(0));
        @(negedge PCLK);
        PRESET = 1'b1; bus.PREADY = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge PCLK);
            #1; chk("arst_no_rsp", 64'(rsp_valid), 64'(0));
        end
        bus.PREADY = 0;
        txn(1'b0, 8'h5A, 32'h0, 4'h0, 3'h4, 1, 1'b0, 32'h5A5A5A5A);

        // TIMEOUT=0 instance: 100 stalled ACCESS cycles must not abort
        @(negedge PCLK);
        z_valid = 1; z_write = 0; z_addr = 8'h77;
        @(negedge PCLK);
        z_valid = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge PCLK);
            bus0.PSLVERR = 1'($urandom);
            #1;
            chk("notimeout_penable", 64'(bus0.PENABLE), 64'(1));
            chk("notimeout_rsp",     64'(z_rsp_valid),  64'(0));
        end
        @(negedge PCLK);
        bus0.PREADY = 1; bus0.PSLVERR = 0; bus0.PRDATA = 32'hCAFEF00D;
        @(negedge PCLK);
        bus0.PREADY = 0;
        #1;
        chk("notimeout_rsp_valid", 64'(z_rsp_valid),   64'(1));
        chk("notimeout_rdata",     64'(z_rsp_rdata),   64'(32'hCAFEF00D));
        chk("notimeout_err",       64'(z_rsp_err),     64'(0));
        chk("notimeout_to",        64'(z_rsp_timeout), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/apb_master_gen.md
Name: apb_master_gen

Overview:
Parametrised APB4 requester. It converts a valid/ready command interface into APB SETUP/ACCESS transfers and supports wait states. It captures read data and PSLVERR into a one-cycle response pulse, supports back-to-back transfers without an IDLE bubble, and aborts stalled transfers with a programmable timeout. It sits between the bus-bridge command logic and the APB slave fabric.

Parameters:
ADDR_W, 8, width of PADDR/req_addr
DATA_W, 32, width of PWDATA/PRDATA/req_wdata/rsp_rdata (8, 16 or 32 only)
TIMEOUT, 16, max ACCESS cycles with PREADY low before abort; 0 = timeout disabled

Ports:
PCLK  in  1  APB clock
PRESET  in  1  asynchronous active-low reset
req_valid  in  1  command valid
req_ready  out  1  command accepted when req_valid && req_ready at PCLK rise
req_write  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  transfer address
req_wdata  in  DATA_W  write data
req_strb  in  DATA_W/8  write byte strobes
req_prot  in  3  protection attributes
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  DATA_W  read data (0 for writes and timeouts)
rsp_err  out  1  PSLVERR or timeout
rsp_timeout  out  1  transfer aborted by timeout
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PADDR  out  ADDR_W  APB address
PWDATA  out  DATA_W  APB write data
PSTRB  out  DATA_W/8  APB strobes
PPROT  out  3  APB protection
PRDATA  in  DATA_W  slave read data
PREADY  in  1  slave ready
PSLVERR  in  1  slave error, sampled only with PREADY in ACCESS

Behaviour:
- Reset (PRESET low, asynchronous): state IDLE; all outputs 0, including req_ready, rsp_*, PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB and PPROT; timeout counter 0. Reset mid-transfer drops the transfer and produces no response.
- All APB and rsp outputs are registered. req_ready is combinational from state and PREADY.
- States: IDLE, SETUP, ACCESS.
- req_ready = (state==IDLE) || (state==ACCESS && PREADY). It is 0 in SETUP and on a timeout-abort cycle.
- IDLE: PSEL=0, PENABLE=0. On accept, register PADDR=req_addr, PWRITE=req_write, PPROT=req_prot. For writes, PWDATA=req_wdata and PSTRB=req_strb. For reads, PWDATA and PSTRB are 0. Then go to SETUP.
- SETUP: PSEL=1, PENABLE=0. Go to ACCESS unconditionally. Counter cleared.
- ACCESS: PSEL=1, PENABLE=1. PADDR, PWRITE, PWDATA, PSTRB and PPROT stay stable.
  - PREADY=1: transfer completes. Next cycle rsp_valid=1, rsp_err=PSLVERR, rsp_timeout=0, rsp_rdata=PRDATA for reads and 0 for writes. If req_valid is also high that cycle, the new command is latched and the next state is SETUP (back-to-back, no IDLE cycle). Otherwise go to IDLE with PSEL=0.
  - PREADY=0, TIMEOUT>0, counter==TIMEOUT-1: abort. Go to IDLE. Next cycle rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0. No command is accepted that cycle.
  - PREADY=0 otherwise: counter increments (saturating width clog2(TIMEOUT+1)) and the state stays in ACCESS.
- Latency: accept at edge N, SETUP in cycle N+1, ACCESS from N+2. With zero wait states, rsp_valid is high in cycle N+3. Each wait state adds 1 cycle.
- rsp_valid is high for exactly 1 cycle per accepted command. There is no backpressure on rsp.
- After IDLE is reached, PADDR, PWRITE and PPROT hold their last values. PSEL=0 qualifies them.
- PSLVERR is ignored unless PSEL && PENABLE && PREADY.

Test Plan:
- Write, 0 wait states: req addr=0x3C, wdata=0xDEADBEEF, strb=0xF → SETUP with PSEL=1/PENABLE=0, then ACCESS; rsp_valid in cycle N+3, rsp_err=0, rsp_rdata=0.
- Read with 3 wait states: addr=0x10, PREADY low for 3 ACCESS cycles, PRDATA=0x12345678 → ACCESS lasts 4 cycles; rsp_rdata=0x12345678; PSTRB=0 and PWDATA=0 throughout.
- Back-to-back: req_valid held high with write 0x04 then read 0x08 → ACCESS(0x04) is followed directly by SETUP(0x08), PSEL stays 1 with no IDLE cycle; two rsp pulses, 3 cycles apart.
- Slave error: read 0x20 with PSLVERR=1 on the PREADY cycle → rsp_err=1, rsp_timeout=0. PSLVERR=1 while PREADY=0 has no effect.
- Timeout: TIMEOUT=4, PREADY stuck low → exactly 4 ACCESS cycles, then PSEL=0; rsp_valid with rsp_err=1, rsp_timeout=1, rsp_rdata=0. With TIMEOUT=0, 100 stalled cycles produce no abort.
- Reset in ACCESS: PRESET low mid wait-state → all outputs 0 immediately (async); no rsp_valid after release; next command runs normally.
